// File: rtl/multi_key_watcher_pkg.sv
// rtl/multi_key_watcher_pkg.sv - shared prefix codes, decoder state encoding and key event type
package keyboard_pkg;

  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
  localparam logic [7:0] EXT_CODE_DEF   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       valid;
    logic       is_break;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/multi_key_watcher_if.sv
// rtl/multi_key_watcher_if.sv - scan-code input, watch table and key-state outputs
// master: code source / key-state consumer (drives code_valid, data, watch_values)
// slave : the watcher (drives status, press_pulse, release_pulse, any_down, proto_err)
interface multi_key_watcher_if #(
  parameter int NUM_KEYS = 4
);
  logic                    code_valid;
  logic [7:0]              data;
  logic [9*NUM_KEYS-1:0]   watch_values;
  logic [NUM_KEYS-1:0]     status;
  logic [NUM_KEYS-1:0]     press_pulse;
  logic [NUM_KEYS-1:0]     release_pulse;
  logic                    any_down;
  logic                    proto_err;

  modport master (
    output code_valid, data, watch_values,
    input  status, press_pulse, release_pulse, any_down, proto_err
  );

  modport slave (
    input  code_valid, data, watch_values,
    output status, press_pulse, release_pulse, any_down, proto_err
  );
endinterface

// File: rtl/multi_key_watcher_ps2_prefix_decoder.sv
// rtl/multi_key_watcher_ps2_prefix_decoder.sv - E0/F0 prefix FSM emitting one make/break event per code
// Ports: clk, rst (async active-low), i_code_valid/i_data (byte strobe),
//        o_event (combinational, valid in the sampling cycle), o_proto_err (registered pulse)
module ps2_prefix_decoder
  import keyboard_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] EXT_CODE   = EXT_CODE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_code_valid,
  input  logic [7:0] i_data,
  output key_event_t o_event,
  output logic       o_proto_err
);

  dec_state_t r_state;
  dec_state_t w_next;
  key_event_t w_event;
  logic       w_err;
  logic       r_proto_err;
  logic       w_is_ext;
  logic       w_is_brk;

  assign w_is_ext = (i_data == EXT_CODE);
  assign w_is_brk = (i_data == BREAK_CODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_proto_err <= w_err;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_err   = 1'b0;
    w_event = '0;
    if (i_code_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_ext)      w_next = ST_EXT;
          else if (w_is_brk) w_next = ST_BRK;
          else w_event = '{valid: 1'b1, is_break: 1'b0, ext: 1'b0, code: i_data};
        end
        ST_EXT: begin
          // A repeated E0 is tolerated and keeps us waiting for the code byte.
          if (w_is_brk)      w_next = ST_EXT_BRK;
          else if (w_is_ext) w_next = ST_EXT;
          else begin
            w_event = '{valid: 1'b1, is_break: 1'b0, ext: 1'b1, code: i_data};
            w_next  = ST_IDLE;
          end
        end
        ST_BRK: begin
          // F0 F0 is tolerated; F0 E0 is an out-of-order prefix.
          if (w_is_ext) begin
            w_err  = 1'b1;
            w_next = ST_IDLE;
          end else if (w_is_brk) begin
            w_next = ST_BRK;
          end else begin
            w_event = '{valid: 1'b1, is_break: 1'b1, ext: 1'b0, code: i_data};
            w_next  = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (w_is_ext || w_is_brk) begin
            w_err  = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_event = '{valid: 1'b1, is_break: 1'b1, ext: 1'b1, code: i_data};
            w_next  = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign o_event     = w_event;
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/multi_key_watcher.sv
// rtl/multi_key_watcher.sv - tracks up/down state of NUM_KEYS keys from one PS/2 scan-code stream
// Ports: clk, rst (async active-low), bus (multi_key_watcher_if.slave):
//        code_valid/data in, watch_values table in, status/press_pulse/release_pulse/any_down/proto_err out
module multi_key_watcher
  import keyboard_pkg::*;
#(
  parameter int         NUM_KEYS   = 4,
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] EXT_CODE   = EXT_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  multi_key_watcher_if.slave bus
);

  key_event_t          w_event;
  logic                w_proto_err;
  logic [NUM_KEYS-1:0] w_status;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;

  ps2_prefix_decoder #(
    .BREAK_CODE (BREAK_CODE),
    .EXT_CODE   (EXT_CODE)
  ) u_decoder (
    .clk          (clk),
    .rst          (rst),
    .i_code_valid (bus.code_valid),
    .i_data       (bus.data),
    .o_event      (w_event),
    .o_proto_err  (w_proto_err)
  );

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [8:0] w_watch;
    logic       w_match;
    logic       r_status;
    logic       r_press;
    logic       r_release;

    assign w_watch = bus.watch_values[9*k +: 9];
    // Extended flag is part of the compare, so E0-prefixed and plain codes never alias.
    assign w_match = w_event.valid && ({w_event.ext, w_event.code} == w_watch);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_status  <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (w_match) begin
          // Typematic repeats and breaks of keys already up fall through untouched.
          if (!w_event.is_break && !r_status) begin
            r_status <= 1'b1;
            r_press  <= 1'b1;
          end else if (w_event.is_break && r_status) begin
            r_status  <= 1'b0;
            r_release <= 1'b1;
          end
        end
      end
    end

    assign w_status[k]  = r_status;
    assign w_press[k]   = r_press;
    assign w_release[k] = r_release;
  end

  assign bus.status        = w_status;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_release;
  assign bus.any_down      = |w_status;
  assign bus.proto_err     = w_proto_err;

endmodule

// File: tb/tb_multi_key_watcher.sv
// tb/tb_multi_key_watcher.sv - scoreboard bench for multi_key_watcher
module tb_multi_key_watcher;

  typedef struct {
    int         id;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       er;
    logic       ad;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   step_id = 0;
  exp_t m_e;

  always #5 clk = ~clk;

  multi_key_watcher_if #(.NUM_KEYS(4)) bus ();

  multi_key_watcher #(
    .NUM_KEYS   (4),
    .BREAK_CODE (8'hF0),
    .EXT_CODE   (8'hE0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive one cycle of input and queue the outputs expected after the next rising edge.
  task automatic step(input logic rv, input logic v, input logic [7:0] d,
                      input logic [3:0] st, input logic [3:0] pr,
                      input logic [3:0] rl, input logic er);
    exp_t e;
    @(negedge clk);
    rst            = rv;
    bus.code_valid = v;
    bus.data       = d;
    e.id = step_id;
    e.st = st;
    e.pr = pr;
    e.rl = rl;
    e.er = er;
    e.ad = (st != 4'b0000);
    q.push_back(e);
    step_id++;
  endtask

  task automatic b(input logic [7:0] d, input logic [3:0] st, input logic [3:0] pr,
                   input logic [3:0] rl, input logic er);
    step(1'b1, 1'b1, d, st, pr, rl, er);
  endtask

  task automatic idle(input logic [7:0] d, input logic [3:0] st);
    step(1'b1, 1'b0, d, st, 4'b0, 4'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      checks++;
      if (bus.status !== m_e.st || bus.press_pulse !== m_e.pr ||
          bus.release_pulse !== m_e.rl || bus.proto_err !== m_e.er ||
          bus.any_down !== m_e.ad) begin
        errs++;
        $display("FAIL step%0d outputs: got st=%b pr=%b rl=%b err=%b any=%b, want st=%b pr=%b rl=%b err=%b any=%b",
                 m_e.id, bus.status, bus.press_pulse, bus.release_pulse, bus.proto_err, bus.any_down,
                 m_e.st, m_e.pr, m_e.rl, m_e.er, m_e.ad);
      end
    end
  end

  initial begin
    // key0 {0,1C}, key1 {1,75}, key2 {0,75}, key3 {1,1C}
    rst              = 1'b0;
    bus.code_valid   = 1'b0;
    bus.data         = 8'h00;
    bus.watch_values = {9'h11C, 9'h075, 9'h175, 9'h01C};

    step(1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 8'h1C, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Basic make / break of a plain key
    b(8'h1C, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b0000, 4'b0000, 4'b0001, 1'b0);

    // Extended key, plain 75 only hits the plain watch
    b(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    b(8'h75, 4'b0010, 4'b0010, 4'b0000, 1'b0);
    b(8'h75, 4'b0110, 4'b0100, 4'b0000, 1'b0);
    b(8'hE0, 4'b0110, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b0110, 4'b0000, 4'b0000, 1'b0);
    b(8'h75, 4'b0100, 4'b0000, 4'b0010, 1'b0);
    b(8'hF0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    b(8'h75, 4'b0000, 4'b0000, 4'b0100, 1'b0);

    // Typematic repeat
    b(8'h1C, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    b(8'h1C, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b0000, 4'b0000, 4'b0001, 1'b0);

    // E0 1C is key3 only; plain break of key0 while up is ignored
    b(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b1000, 4'b1000, 4'b0000, 1'b0);
    b(8'hF0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    b(8'hE0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b0000, 4'b0000, 4'b1000, 1'b0);

    // Protocol errors leave status alone and return decoder to IDLE
    b(8'h1C, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'hE0, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    b(8'h1C, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'hE0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    b(8'h1C, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b0000, 4'b0000, 4'b0001, 1'b0);

    // Redundant E0 tolerated; E0 F0 E0 is an error
    b(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    b(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    b(8'h75, 4'b0010, 4'b0010, 4'b0000, 1'b0);
    b(8'hE0, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    b(8'hF0, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    b(8'hE0, 4'b0010, 4'b0000, 4'b0000, 1'b1);
    b(8'h75, 4'b0110, 4'b0100, 4'b0000, 1'b0);
    b(8'hF0, 4'b0110, 4'b0000, 4'b0000, 1'b0);
    b(8'h75, 4'b0010, 4'b0000, 4'b0100, 1'b0);

    // Two keys down, then reset in the middle of E0 F0
    b(8'h1C, 4'b0011, 4'b0001, 4'b0000, 1'b0);
    b(8'hE0, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 8'hF0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    idle(8'h00, 4'b0000);
    b(8'h75, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    b(8'hF0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    b(8'h75, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    b(8'hF0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // code_valid low with data toggling holds everything
    b(8'h1C, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      idle((i % 2 == 0) ? 8'hF0 : 8'h1C, 4'b0001);
    end
    b(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    b(8'h1C, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    idle(8'h00, 4'b0000);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
